// File: rtl/prog_loader_pkg.sv
// Shared state encoding and stream constants for the boot-time program loader.
package prog_loader_pkg;

   localparam logic [2:0] LEN_LO = 3'd0;
   localparam logic [2:0] LEN_HI = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] CHK    = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;
   localparam logic [2:0] ERROR  = 3'd5;

   localparam int LEN_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/prog_loader_word_asm.sv
// Little-endian byte-to-word assembler for the program loader.
// word_o/word_valid_o are combinational so the 4th byte's word is ready at its accept edge.
module prog_loader_word_asm
   import prog_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_valid_o
);

   localparam int BW = $clog2(BYTES_PER_WORD);

   logic [BW-1:0] byte_cnt;
   logic [23:0]   lanes;

   always_ff @(posedge clk) begin
      if (reset) begin
         byte_cnt <= '0;
         lanes    <= '0;
      end else if (byte_valid_i) begin
         byte_cnt <= byte_cnt + 1'b1;
         unique case (byte_cnt)
            2'd0:    lanes[7:0]   <= byte_i;
            2'd1:    lanes[15:8]  <= byte_i;
            2'd2:    lanes[23:16] <= byte_i;
            default: ;
         endcase
      end
   end

   assign word_o       = {byte_i, lanes};
   assign word_valid_o = byte_valid_i &&
                         (byte_cnt == BW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Boot loader: length-prefixed byte stream into program memory, core held in reset.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int PROGRAM_MEMORY_DEPTH = 128,
   parameter int MAX_WORDS            = PROGRAM_MEMORY_DEPTH
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    rx_valid_i,
   input  logic [7:0]                              rx_data_i,
   output logic                                    rx_ready_o,
   output logic                                    wr_en_o,
   output logic [$clog2(PROGRAM_MEMORY_DEPTH)-1:0] wr_addr_o,
   output logic [31:0]                             wr_data_o,
   output logic                                    core_reset_o,
   output logic                                    done_o,
   output logic                                    error_o
);

   localparam int          AW    = $clog2(PROGRAM_MEMORY_DEPTH);
   localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

`ifdef PROG_LOADER_CHECKSUM_EN
   localparam logic [2:0] END_ST = CHK;
   logic [7:0] csum;
`else
   localparam logic [2:0] END_ST = DONE;
`endif

   logic [2:0]    state;
   logic [7:0]    len_lo;
   logic [15:0]   n_words;
   logic [AW-1:0] word_idx;
   logic          byte_acc;
   logic          word_valid;
   logic          last_word;
   logic [31:0]   word;
   logic [15:0]   len_full;

   assign rx_ready_o = (state == LEN_LO) || (state == LEN_HI) ||
                       (state == DATA)   || (state == CHK);
   assign byte_acc   = rx_valid_i && rx_ready_o;
   assign len_full   = {rx_data_i, len_lo};
   assign last_word  = ({{(16-AW){1'b0}}, word_idx} == n_words - 16'd1);
   assign done_o     = (state == DONE);
   assign error_o    = (state == ERROR);

   prog_loader_word_asm u_word_asm (
      .clk          (clk),
      .reset        (reset),
      .byte_valid_i (byte_acc && (state == DATA)),
      .byte_i       (rx_data_i),
      .word_o       (word),
      .word_valid_o (word_valid)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= LEN_LO;
         len_lo       <= '0;
         n_words      <= '0;
         word_idx     <= '0;
         wr_en_o      <= 1'b0;
         wr_addr_o    <= '0;
         wr_data_o    <= '0;
         core_reset_o <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
         csum         <= '0;
`endif
      end else begin
         wr_en_o <= 1'b0;
         // Release lags done by a cycle so the last write settles first.
         core_reset_o <= ~done_o;
         if (byte_acc) begin
            unique case (1'b1)
               state == LEN_LO: begin
                  len_lo <= rx_data_i;
                  state  <= LEN_HI;
               end
               state == LEN_HI: begin
                  n_words <= len_full;
                  if (len_full == 16'd0)
                     state <= END_ST;
                  else if (len_full > MAX_N)
                     state <= ERROR;
                  else
                     state <= DATA;
               end
               state == DATA: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                  csum <= csum ^ rx_data_i;
`endif
                  if (word_valid) begin
                     wr_en_o   <= 1'b1;
                     wr_addr_o <= word_idx;
                     wr_data_o <= word;
                     if (last_word)
                        state <= END_ST;
                     else
                        word_idx <= word_idx + 1'b1;
                  end
               end
`ifdef PROG_LOADER_CHECKSUM_EN
               state == CHK:
                  state <= (rx_data_i == csum) ? DONE : ERROR;
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: stream-level model plus literal spot checks.
module tb_prog_loader;

`ifdef PROG_LOADER_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif
   localparam int MAXW = 128;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_ready_o;
   logic        wr_en_o;
   logic [6:0]  wr_addr_o;
   logic [31:0] wr_data_o;
   logic        core_reset_o;
   logic        done_o;
   logic        error_o;

   prog_loader #(.PROGRAM_MEMORY_DEPTH(128)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_valid_i   (rx_valid),
      .rx_data_i    (rx_data),
      .rx_ready_o   (rx_ready_o),
      .wr_en_o      (wr_en_o),
      .wr_addr_o    (wr_addr_o),
      .wr_data_o    (wr_data_o),
      .core_reset_o (core_reset_o),
      .done_o       (done_o),
      .error_o      (error_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Stream-position model: tracks bytes accepted since reset.
   int         m_pos, m_n, m_addr;
   bit         m_done, m_err, m_ready, m_wr, m_core_reset, m_old_done;
   bit         cmp_en = 1'b0;
   logic [7:0] m_lane [4];
   logic [7:0] m_csum;
   logic [31:0] m_data;
   int         k;

   always @(posedge clk) begin
      m_old_done = m_done;
      if (reset) begin
         m_pos = 0; m_n = 0; m_addr = 0; m_data = 0;
         m_done = 0; m_err = 0; m_ready = 1; m_wr = 0;
         m_core_reset = 1; m_csum = 0;
      end else begin
         m_wr = 0;
         m_core_reset = !m_old_done;
         if (rx_valid && m_ready) begin
            if (m_pos == 0) m_n = int'(rx_data);
            else if (m_pos == 1) begin
               m_n = m_n + 256 * int'(rx_data);
               if (m_n > MAXW) m_err = 1;
               else if (m_n == 0 && !CK) m_done = 1;
            end else if (m_pos < 2 + 4 * m_n) begin
               k = m_pos - 2;
               m_lane[k % 4] = rx_data;
               m_csum = m_csum ^ rx_data;
               if (k % 4 == 3) begin
                  m_wr = 1;
                  m_addr = k / 4;
                  m_data = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
               end
               if (k == 4 * m_n - 1 && !CK) m_done = 1;
            end else begin
               if (rx_data == m_csum) m_done = 1;
               else m_err = 1;
            end
            m_pos++;
         end
         m_ready = !m_done && !m_err;
      end
      cmp_en = 1'b1;
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("rx_ready", {31'd0, rx_ready_o}, {31'd0, m_ready});
         chk("wr_en", {31'd0, wr_en_o}, {31'd0, m_wr});
         chk("wr_addr", {25'd0, wr_addr_o}, 32'(m_addr));
         chk("wr_data", wr_data_o, m_data);
         chk("done", {31'd0, done_o}, {31'd0, m_done});
         chk("error", {31'd0, error_o}, {31'd0, m_err});
         chk("core_reset", {31'd0, core_reset_o}, {31'd0, m_core_reset});
      end
   end

   logic [31:0] log_mem [128];
   int          wr_cnt = 0;

   always @(negedge clk) begin
      if (wr_en_o === 1'b1) begin
         log_mem[wr_addr_o] = wr_data_o;
         wr_cnt++;
      end
   end

   logic [7:0] stim [$];

   task automatic apply_reset();
      reset = 1'b1;
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      wr_cnt = 0;
      for (int i = 0; i < 128; i++) log_mem[i] = 32'h0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      rx_valid = 1'b1;
      rx_data = b;
      t = 0;
      while (rx_ready_o !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         failures++;
         $display("FAIL send_timeout actual=stalled required=accept byte=%h", b);
      end
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_all(input int gap);
      foreach (stim[i]) send_byte(stim[i], gap);
      stim.delete();
   endtask

   task automatic push_two_words();
      stim.push_back(8'h02); stim.push_back(8'h00);
      stim.push_back(8'h13); stim.push_back(8'h05);
      stim.push_back(8'h50); stim.push_back(8'h00);
      stim.push_back(8'h93); stim.push_back(8'h05);
      stim.push_back(8'hA0); stim.push_back(8'h00);
   endtask

   task automatic push_csum(input logic [7:0] c);
      if (CK) stim.push_back(c);
   endtask

   task automatic check_two_words(input string tag);
      chk({tag, "_mem0"}, log_mem[0], 32'h00500513);
      chk({tag, "_mem1"}, log_mem[1], 32'h00A00593);
      chk({tag, "_wrcnt"}, 32'(wr_cnt), 32'd2);
      chk({tag, "_done"}, {31'd0, done_o}, 32'd1);
      chk({tag, "_core_reset"}, {31'd0, core_reset_o}, 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Idle after reset
      repeat (6) @(negedge clk);
      chk("idle_core_reset", {31'd0, core_reset_o}, 32'd1);
      chk("idle_ready", {31'd0, rx_ready_o}, 32'd1);
      chk("idle_done", {31'd0, done_o}, 32'd0);
      chk("idle_wrcnt", 32'(wr_cnt), 32'd0);

      // Back-to-back two-word image
      push_two_words();
      push_csum(8'h70);
      send_all(0);
      repeat (3) @(negedge clk);
      check_two_words("b2b");

      // Bytes offered after done are ignored
      rx_valid = 1'b1;
      rx_data = 8'hFF;
      repeat (3) @(negedge clk);
      rx_valid = 1'b0;
      @(negedge clk);
      chk("post_done_wrcnt", 32'(wr_cnt), 32'd2);

      // Stalled stream
      apply_reset();
      push_two_words();
      push_csum(8'h70);
      send_all(1);
      repeat (3) @(negedge clk);
      check_two_words("gap");

      // Oversized count
      apply_reset();
      stim.push_back(8'h81); stim.push_back(8'h00);
      send_all(0);
      repeat (3) @(negedge clk);
      chk("big_error", {31'd0, error_o}, 32'd1);
      chk("big_core_reset", {31'd0, core_reset_o}, 32'd1);
      chk("big_ready", {31'd0, rx_ready_o}, 32'd0);
      chk("big_wrcnt", 32'(wr_cnt), 32'd0);

      // Reset mid-load, then reload
      apply_reset();
      push_two_words();
      stim = stim[0:7];
      send_all(0);
      apply_reset();
      chk("midrst_done", {31'd0, done_o}, 32'd0);
      chk("midrst_core_reset", {31'd0, core_reset_o}, 32'd1);
      push_two_words();
      push_csum(8'h70);
      send_all(0);
      repeat (3) @(negedge clk);
      check_two_words("reload");

      // Empty image
      apply_reset();
      stim.push_back(8'h00); stim.push_back(8'h00);
      push_csum(8'h00);
      send_all(0);
      repeat (3) @(negedge clk);
      chk("empty_done", {31'd0, done_o}, 32'd1);
      chk("empty_wrcnt", 32'(wr_cnt), 32'd0);

      // Full-depth image: word i = 32'h10000000 + i
      apply_reset();
      stim.push_back(8'h80); stim.push_back(8'h00);
      for (int i = 0; i < 128; i++) begin
         stim.push_back(8'(i)); stim.push_back(8'h00);
         stim.push_back(8'h00); stim.push_back(8'h10);
      end
      push_csum(8'h00);
      send_all(0);
      repeat (3) @(negedge clk);
      chk("full_mem0", log_mem[0], 32'h10000000);
      chk("full_mem127", log_mem[127], 32'h1000007F);
      chk("full_wrcnt", 32'(wr_cnt), 32'd128);
      chk("full_done", {31'd0, done_o}, 32'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
      apply_reset();
      push_two_words();
      stim.push_back(8'h71);
      send_all(0);
      repeat (3) @(negedge clk);
      chk("badck_error", {31'd0, error_o}, 32'd1);
      chk("badck_core_reset", {31'd0, core_reset_o}, 32'd1);
      chk("badck_done", {31'd0, done_o}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
